// File: rtl/branch_cond_if.sv
// Branch request / branch result handshake bundle between decode, the
// branch-resolution stage and fetch.
interface branch_cond_if #(
    parameter int ADDR_W = 32
);
    // request side: decode -> branch stage
    logic              br_valid;
    logic              br_ready;
    logic [2:0]        br_cond;
    logic [ADDR_W-1:0] br_pc;
    logic [ADDR_W-1:0] br_offset;
    // result side: branch stage -> fetch
    logic              res_valid;
    logic              res_ready;
    logic              res_taken;
    logic [ADDR_W-1:0] res_target;

    // issuer of branch requests and consumer of results
    modport master (
        output br_valid, br_cond, br_pc, br_offset, res_ready,
        input  br_ready, res_valid, res_taken, res_target
    );

    // the branch-resolution stage itself
    modport slave (
        input  br_valid, br_cond, br_pc, br_offset, res_ready,
        output br_ready, res_valid, res_taken, res_target
    );
endinterface

// File: rtl/branch_cond.sv
// Flag register and branch-resolution stage. Holds the last compare flags
// {N,Z,C,V}, resolves one branch at a time against them (forwarding flags
// that arrive in the same cycle) and hands taken/target to fetch.
module branch_cond #(
    parameter int ADDR_W  = 32,
    parameter int PC_STEP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flag_valid,
    input  logic [3:0]        flag_in,
    input  logic              flag_clr,
    branch_cond_if.slave      bus,
    output logic [3:0]        flags_q
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_F = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        flags_d;
    logic              flags_vld_q, flags_vld_d;
    logic [2:0]        cond_q, cond_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] off_q, off_d;
    logic              res_valid_q, res_valid_d;
    logic              res_taken_q, res_taken_d;
    logic [ADDR_W-1:0] res_target_q, res_target_d;
    logic              br_ready_q, br_ready_d;
    logic [3:0]        eff_flags_s;
    logic              eff_vld_s;

    // Condition-code evaluation; flag layout is {N,Z,C,V}.
    function automatic logic cond_met(input logic [2:0] cond, input logic [3:0] f);
        logic r;
        case (cond)
            3'b000:  r = 1'b1;
            3'b001:  r = f[2];
            3'b010:  r = ~f[2];
            3'b011:  r = f[3];
            3'b100:  r = ~f[3];
            3'b101:  r = ~f[3] & ~f[2];
            3'b110:  r = f[3] | f[2];
            3'b111:  r = f[1] | f[0];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Next PC: wraps silently modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] next_pc(input logic taken,
                                                   input logic [ADDR_W-1:0] pc,
                                                   input logic [ADDR_W-1:0] off);
        logic [ADDR_W-1:0] t;
        if (taken) begin
            t = pc + off;
        end else begin
            t = pc + ADDR_W'(PC_STEP);
        end
        return t;
    endfunction

    // Flags seen by an accepting branch: a same-cycle compare result wins.
    always_comb begin
        if (flag_valid) begin
            eff_flags_s = flag_in;
        end else begin
            eff_flags_s = flags_q;
        end
        eff_vld_s = flag_valid | flags_vld_q;
    end

    // Next-state logic for the flag register, the request latch and the FSM.
    always_comb begin
        state_d      = state_q;
        flags_d      = flags_q;
        flags_vld_d  = flags_vld_q;
        cond_d       = cond_q;
        pc_d         = pc_q;
        off_d        = off_q;
        res_valid_d  = res_valid_q;
        res_taken_d  = res_taken_q;
        res_target_d = res_target_q;

        // a new compare result beats a flush in the same cycle
        if (flag_valid) begin
            flags_d     = flag_in;
            flags_vld_d = 1'b1;
        end else if (flag_clr) begin
            flags_vld_d = 1'b0;
        end else begin
            flags_vld_d = flags_vld_q;
        end

        case (state_q)
            IDLE: begin
                if (bus.br_valid) begin
                    cond_d = bus.br_cond;
                    pc_d   = bus.br_pc;
                    off_d  = bus.br_offset;
                    if ((bus.br_cond == 3'b000) || eff_vld_s) begin
                        res_taken_d  = cond_met(bus.br_cond, eff_flags_s);
                        res_target_d = next_pc(res_taken_d, bus.br_pc, bus.br_offset);
                        res_valid_d  = 1'b1;
                        state_d      = RESP;
                    end else begin
                        state_d = WAIT_F;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_F: begin
                // only a fresh compare releases a parked branch
                if (flag_valid) begin
                    res_taken_d  = cond_met(cond_q, flag_in);
                    res_target_d = next_pc(res_taken_d, pc_q, off_q);
                    res_valid_d  = 1'b1;
                    state_d      = RESP;
                end else begin
                    state_d = WAIT_F;
                end
            end
            RESP: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        br_ready_d = (state_d == IDLE);
    end

    // State and output registers; reset discards any pending request/result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            flags_q      <= 4'b0000;
            flags_vld_q  <= 1'b0;
            cond_q       <= 3'b000;
            pc_q         <= {ADDR_W{1'b0}};
            off_q        <= {ADDR_W{1'b0}};
            res_valid_q  <= 1'b0;
            res_taken_q  <= 1'b0;
            res_target_q <= {ADDR_W{1'b0}};
            br_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            flags_q      <= flags_d;
            flags_vld_q  <= flags_vld_d;
            cond_q       <= cond_d;
            pc_q         <= pc_d;
            off_q        <= off_d;
            res_valid_q  <= res_valid_d;
            res_taken_q  <= res_taken_d;
            res_target_q <= res_target_d;
            br_ready_q   <= br_ready_d;
        end
    end

    assign bus.br_ready   = br_ready_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_taken  = res_taken_q;
    assign bus.res_target = res_target_q;

endmodule

// File: tb/tb_branch_cond.sv
// Bench for branch_cond: directed scenarios followed by random traffic, all
// compared against a transaction-level reference model.
module tb_branch_cond;

    logic       clk;
    logic       rst_n;
    logic       flag_valid;
    logic [3:0] flag_in;
    logic       flag_clr;
    logic [3:0] flags_q;

    branch_cond_if #(.ADDR_W(32)) bif ();

    branch_cond #(.ADDR_W(32), .PC_STEP(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flag_valid (flag_valid),
        .flag_in    (flag_in),
        .flag_clr   (flag_clr),
        .bus        (bif),
        .flags_q    (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model: what the stage "knows"
    logic [3:0]  m_flags;
    bit          m_fvld;
    bit          m_wait;   // branch parked, no flags yet
    bit          m_res;    // result being offered
    logic [2:0]  m_cond;
    logic [31:0] m_pc, m_off;
    bit          m_taken;
    logic [31:0] m_tgt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_taken(input logic [2:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return n;
            3'd4: return !n;
            3'd5: return !n && !z;
            3'd6: return n || z;
            3'd7: return cy || v;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_flags = 4'h0; m_fvld = 0; m_wait = 0; m_res = 0;
        m_taken = 0; m_tgt = 32'h0;
    endtask

    task automatic resolve(input logic [3:0] f);
        m_taken = exp_taken(m_cond, f);
        m_tgt   = m_taken ? (m_pc + m_off) : (m_pc + 32'd4);
        m_res   = 1;
        m_wait  = 0;
    endtask

    // advance the model by one clock using the inputs present at the edge
    task automatic model_update();
        logic [3:0] eff;
        bit effv;
        eff  = flag_valid ? flag_in : m_flags;
        effv = flag_valid || m_fvld;
        if (m_res) begin
            if (bif.res_ready) m_res = 0;
        end else if (m_wait) begin
            if (flag_valid) resolve(flag_in);
        end else if (bif.br_valid) begin
            m_cond = bif.br_cond; m_pc = bif.br_pc; m_off = bif.br_offset;
            if (m_cond == 3'd0 || effv) resolve(eff);
            else m_wait = 1;
        end
        if (flag_valid) begin
            m_flags = flag_in; m_fvld = 1;
        end else if (flag_clr) begin
            m_fvld = 0;
        end
    endtask

    task automatic compare();
        check("res_valid", 64'(bif.res_valid), 64'(m_res));
        check("br_ready", 64'(bif.br_ready), 64'(!m_wait && !m_res));
        check("flags_q", 64'(flags_q), 64'(m_flags));
        if (m_res) begin
            check("res_taken", 64'(bif.res_taken), 64'(m_taken));
            check("res_target", 64'(bif.res_target), 64'(m_tgt));
        end
    endtask

    // one clock: entered at a falling edge with inputs already driven
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare();
        @(negedge clk);
    endtask

    task automatic cyc(input bit fv, input logic [3:0] fin, input bit fc,
                       input bit bv, input logic [2:0] cond,
                       input logic [31:0] pc, input logic [31:0] off, input bit rr);
        flag_valid    = fv;
        flag_in       = fin;
        flag_clr      = fc;
        bif.br_valid  = bv;
        bif.br_cond   = cond;
        bif.br_pc     = pc;
        bif.br_offset = off;
        bif.res_ready = rr;
        step();
    endtask

    task automatic idle_inputs();
        flag_valid = 0; flag_in = 4'h0; flag_clr = 0;
        bif.br_valid = 0; bif.br_cond = 3'd0; bif.br_pc = 32'h0;
        bif.br_offset = 32'h0; bif.res_ready = 0;
    endtask

    // asynchronous reset applied between edges
    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        #1;
        model_reset();
        check("rst_res_valid", 64'(bif.res_valid), 64'd0);
        check("rst_br_ready", 64'(bif.br_ready), 64'd1);
        check("rst_flags_q", 64'(flags_q), 64'd0);
        check("rst_res_taken", 64'(bif.res_taken), 64'd0);
        check("rst_res_target", 64'(bif.res_target), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 1;
        idle_inputs();
        model_reset();
        @(negedge clk);
        apply_reset();

        // 1: stored Z then EQ branch
        cyc(1, 4'b0100, 0, 0, 3'd0, 32'h0, 32'h0, 0);
        cyc(0, 4'h0, 0, 1, 3'd1, 32'h100, 32'h20, 0);
        check("t1_taken", 64'(bif.res_taken), 64'd1);
        check("t1_target", 64'(bif.res_target), 64'h120);
        cyc(0, 4'h0, 0, 0, 3'd0, 32'h0, 32'h0, 1);

        // 2: forwarded N with GE branch
        cyc(1, 4'b1000, 0, 1, 3'd4, 32'h40, 32'h8, 0);
        check("t2_taken", 64'(bif.res_taken), 64'd0);
        check("t2_target", 64'(bif.res_target), 64'h44);
        cyc(0, 4'h0, 0, 0, 3'd0, 32'h0, 32'h0, 1);

        // 3: LT with no flags parks, then resolves
        apply_reset();
        cyc(0, 4'h0, 0, 1, 3'd3, 32'h300, 32'h40, 0);
        check("t3_wait_ready", 64'(bif.br_ready), 64'd0);
        check("t3_wait_valid", 64'(bif.res_valid), 64'd0);
        cyc(1, 4'b1000, 0, 0, 3'd0, 32'h0, 32'h0, 0);
        check("t3_taken", 64'(bif.res_taken), 64'd1);
        check("t3_target", 64'(bif.res_target), 64'h340);

        // 4: result held while new flags arrive
        cyc(1, 4'b0000, 0, 1, 3'd0, 32'h0, 32'h0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 4'h0, 0, 1, 3'd0, 32'h0, 32'h0, 0);
        check("t4_taken", 64'(bif.res_taken), 64'd1);
        check("t4_target", 64'(bif.res_target), 64'h340);
        check("t4_flags", 64'(flags_q), 64'd0);
        cyc(0, 4'h0, 0, 0, 3'd0, 32'h0, 32'h0, 1);

        // 5: target wrap, taken and not taken
        cyc(0, 4'h0, 0, 1, 3'd0, 32'hFFFF_FFF0, 32'h20, 0);
        check("t5_wrap_taken", 64'(bif.res_target), 64'h10);
        cyc(0, 4'h0, 0, 0, 3'd0, 32'h0, 32'h0, 1);
        cyc(1, 4'b0000, 0, 1, 3'd1, 32'hFFFF_FFFC, 32'h100, 0);
        check("t5_wrap_nt_taken", 64'(bif.res_taken), 64'd0);
        check("t5_wrap_nt", 64'(bif.res_target), 64'h0);
        cyc(0, 4'h0, 0, 0, 3'd0, 32'h0, 32'h0, 1);

        // 6: clear and valid together keep flags valid
        cyc(1, 4'b0000, 1, 0, 3'd0, 32'h0, 32'h0, 0);
        cyc(0, 4'h0, 0, 1, 3'd2, 32'h200, 32'h10, 0);
        check("t6_valid", 64'(bif.res_valid), 64'd1);
        check("t6_target", 64'(bif.res_target), 64'h210);
        cyc(0, 4'h0, 0, 0, 3'd0, 32'h0, 32'h0, 1);
        // flush, park a branch, then reset mid-wait
        cyc(0, 4'h0, 1, 0, 3'd0, 32'h0, 32'h0, 0);
        cyc(0, 4'h0, 0, 1, 3'd6, 32'h500, 32'h4, 0);
        check("t6_parked", 64'(bif.br_ready), 64'd0);
        apply_reset();
        cyc(0, 4'h0, 0, 0, 3'd0, 32'h0, 32'h0, 0);
        check("t6_after_rst", 64'(bif.res_valid), 64'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] pc, off;
            pc  = $urandom;
            off = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
            cyc($urandom_range(0, 3) == 0,
                4'($urandom),
                (!m_wait) && ($urandom_range(0, 6) == 0),
                $urandom_range(0, 1) == 1,
                3'($urandom),
                pc, off,
                $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
